mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 65 ++++++
 rtl/mem_arbiter.sv | 107 ++++++++++
 2 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared bus and arbiter types for the fetch/data memory arbiter and its bus side.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY_I = 2'd1,
      ST_BUSY_D = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWNER_I = 1'b0,
      OWNER_D = 1'b1
   } owner_e;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [63:0] addr;
      logic [2:0]  size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } bus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [63:0] data;
   } bus_resp_t;

   typedef struct packed {
      logic        is_write;
      logic [63:0] addr;
      logic [2:0]  size;
      logic [7:0]  strobe;
      logic [63:0] data;
      owner_e      owner;
   } arb_req_t;

   localparam logic [2:0] FETCH_SIZE = 3'b010;

   // Instruction fetches are always 4-byte reads.
   function automatic arb_req_t fetch_req(input logic [63:0] pc);
      arb_req_t r;
      r.is_write = 1'b0;
      r.addr     = pc;
      r.size     = FETCH_SIZE;
      r.strobe   = 8'h00;
      r.data     = 64'h0;
      r.owner    = OWNER_I;
      return r;
   endfunction

   function automatic arb_req_t data_req(input logic [63:0] addr, input logic [2:0] size,
                                         input logic [7:0] strobe, input logic [63:0] data);
      arb_req_t r;
      r.is_write = (strobe != 8'h00);
      r.addr     = addr;
      r.size     = size;
      r.strobe   = strobe;
      r.data     = data;
      r.owner    = OWNER_D;
      return r;
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single-beat bus, one transaction outstanding.
// Bus request comes from a register latched at grant; data_ok is combinational on cresp_last.
module mem_arbiter
   import mem_arbiter_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        ireq_valid,
   input  logic [63:0] ireq_addr,
   output logic        iresp_data_ok,
   output logic [31:0] iresp_data,
   input  logic        dreq_valid,
   input  logic [63:0] dreq_addr,
   input  logic [2:0]  dreq_size,
   input  logic [7:0]  dreq_strobe,
   input  logic [63:0] dreq_data,
   output logic        dresp_data_ok,
   output logic [63:0] dresp_data,
   output logic        creq_valid,
   output logic        creq_is_write,
   output logic [63:0] creq_addr,
   output logic [2:0]  creq_size,
   output logic [7:0]  creq_strobe,
   output logic [63:0] creq_data,
   input  logic        cresp_ready,
   input  logic        cresp_last,
   input  logic [63:0] cresp_data
);

   arb_state_e state_q, state_d;
   owner_e     last_grant_q, last_grant_d;
   arb_req_t   req_q, req_d;
   bus_req_t   creq;
   logic       sel_i, sel_d, done;

   // Data wins a tie unless it also won the previous grant.
   always_comb begin
      sel_i = 1'b0;
      sel_d = 1'b0;
      if (ireq_valid && dreq_valid) begin
         if (last_grant_q == OWNER_D) sel_i = 1'b1;
         else                         sel_d = 1'b1;
      end else begin
         sel_i = ireq_valid;
         sel_d = dreq_valid;
      end
   end

   assign done = cresp_ready && cresp_last;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      req_d        = req_q;
      case (state_q)
         ST_IDLE: begin
            if (sel_i) begin
               state_d      = ST_BUSY_I;
               last_grant_d = OWNER_I;
               req_d        = fetch_req(ireq_addr);
            end else if (sel_d) begin
               state_d      = ST_BUSY_D;
               last_grant_d = OWNER_D;
               req_d        = data_req(dreq_addr, dreq_size, dreq_strobe, dreq_data);
            end
         end
         ST_BUSY_I, ST_BUSY_D: begin
            if (done) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         last_grant_q <= OWNER_I;
         req_q        <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         req_q        <= req_d;
      end
   end

   assign creq.valid    = (state_q != ST_IDLE);
   assign creq.is_write = req_q.is_write;
   assign creq.addr     = req_q.addr;
   assign creq.size     = req_q.size;
   assign creq.strobe   = req_q.strobe;
   assign creq.data     = req_q.data;

   assign creq_valid    = creq.valid;
   assign creq_is_write = creq.is_write;
   assign creq_addr     = creq.addr;
   assign creq_size     = creq.size;
   assign creq_strobe   = creq.strobe;
   assign creq_data     = creq.data;

   // A requester that dropped valid (flush) still lets the bus finish but gets no pulse.
   assign iresp_data_ok = creq.valid && (req_q.owner == OWNER_I) && done && ireq_valid;
   assign dresp_data_ok = creq.valid && (req_q.owner == OWNER_D) && done && dreq_valid;

   assign iresp_data = req_q.addr[2] ? cresp_data[63:32] : cresp_data[31:0];
   assign dresp_data = cresp_data;

endmodule
